// File: rtl/pu_div_queued.sv
`default_nettype none
// ============================================================================
// Module      : pu_div_queued
// Description : Queued signed/unsigned restoring divider PU for the NITTA bus.
//               It has a configurable radix, a result FIFO and invalid flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pu_div_queued #(
    parameter int DATA_WIDTH      = 32,
    parameter int ATTR_WIDTH      = 4,
    parameter int INVALID         = 0,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int QUEUE_DEPTH     = 4,
    parameter int SIGNED          = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic                  signal_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    input  logic                  res_select,
    input  logic                  signal_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  busy,
    output logic                  full
);

    localparam int c_K     = DATA_WIDTH / STEPS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_K + 1);
    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    logic [DATA_WIDTH-1:0] r_dvd;
    logic                  r_dvd_inv;
    logic                  r_pend_vld;
    logic [DATA_WIDTH-1:0] r_pend_a;
    logic [DATA_WIDTH-1:0] r_pend_b;
    logic                  r_pend_inv;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nx;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [DATA_WIDTH-1:0] r_orig;
    logic                  r_a_neg;
    logic                  r_b_neg;
    logic                  r_dz;
    logic                  r_inv;

    logic                  w_push;
    logic                  w_load;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;

    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_dz;
    logic                  w_ovf;

    logic [DATA_WIDTH-1:0] w_rem_n;
    logic [DATA_WIDTH-1:0] w_quo_n;
    logic [DATA_WIDTH:0]   w_sh;

    logic [DATA_WIDTH-1:0] w_res_quo;
    logic [DATA_WIDTH-1:0] w_res_rem;
    logic                  w_res_inv;

    logic [DATA_WIDTH-1:0] r_q_quo [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_rem [QUEUE_DEPTH];
    logic                  r_q_inv [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;

    logic                  w_unused_attr;

    assign w_unused_attr = ^attr_in;

    assign w_full   = (r_count == (c_PTR_W + 1)'(QUEUE_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_pop    = signal_pop && !w_empty;
    // A divisor write may refill the slot on the very edge the engine drains it.
    assign w_accept = signal_wr && signal_sel && (!r_pend_vld || w_load);
    assign busy     = r_pend_vld;
    assign full     = w_full;

    // Operand preparation from the pending slot
    assign w_a_neg = (SIGNED != 0) && r_pend_a[DATA_WIDTH-1];
    assign w_b_neg = (SIGNED != 0) && r_pend_b[DATA_WIDTH-1];
    assign w_a_mag = w_a_neg ? -r_pend_a : r_pend_a;
    assign w_b_mag = w_b_neg ? -r_pend_b : r_pend_b;
    assign w_dz    = (r_pend_b == '0);
    assign w_ovf   = (SIGNED != 0) && (r_pend_a == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                     && (r_pend_b == {DATA_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd      <= '0;
            r_dvd_inv  <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_a   <= '0;
            r_pend_b   <= '0;
            r_pend_inv <= 1'b0;
        end else begin
            if (signal_wr && !signal_sel) begin
                r_dvd     <= data_in;
                r_dvd_inv <= attr_in[INVALID];
            end
            if (w_accept) begin
                r_pend_vld <= 1'b1;
                r_pend_a   <= r_dvd;
                r_pend_b   <= data_in;
                r_pend_inv <= r_dvd_inv | attr_in[INVALID];
            end else if (w_load) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_push     = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_pend_vld) begin
                    w_load     = 1'b1;
                    w_state_nx = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_nx = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                if (!w_full || w_pop) begin
                    w_push = 1'b1;
                    if (r_pend_vld) begin
                        w_load     = 1'b1;
                        w_state_nx = c_ST_RUN;
                    end else begin
                        w_state_nx = c_ST_IDLE;
                    end
                end
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_load) begin
                r_cnt <= c_CNT_W'(c_K);
            end else if (r_state == c_ST_RUN) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    // STEPS_PER_CYCLE unrolled restoring steps; the dividend shifts out of r_quo
    always_comb begin
        w_rem_n = r_rem;
        w_quo_n = r_quo;
        w_sh    = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            w_sh    = {w_rem_n, w_quo_n[DATA_WIDTH-1]};
            w_quo_n = {w_quo_n[DATA_WIDTH-2:0], 1'b0};
            if (w_sh >= {1'b0, r_dvs}) begin
                w_sh       = w_sh - {1'b0, r_dvs};
                w_quo_n[0] = 1'b1;
            end
            w_rem_n = w_sh[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_orig  <= r_pend_a;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_dz    <= w_dz;
            r_inv   <= r_pend_inv | w_dz | w_ovf;
        end else if (r_state == c_ST_RUN) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
        end
    end

    // MIN/-1 needs no special case: negating the MIN magnitude yields MIN again
    assign w_res_quo = r_dz ? '0 : ((r_a_neg ^ r_b_neg) ? -r_quo : r_quo);
    assign w_res_rem = r_dz ? r_orig : (r_a_neg ? -r_rem : r_rem);
    assign w_res_inv = r_inv;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_quo[r_wr_ptr] <= w_res_quo;
            r_q_rem[r_wr_ptr] <= w_res_rem;
            r_q_inv[r_wr_ptr] <= w_res_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        attr_out = '0;
        if (signal_oe) begin
            if (w_empty) begin
                attr_out[INVALID] = 1'b1;
            end else begin
                data_out          = res_select ? r_q_rem[r_rd_ptr] : r_q_quo[r_rd_ptr];
                attr_out[INVALID] = r_q_inv[r_rd_ptr];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pu_div_queued.sv
`default_nettype none
// ============================================================================
// Module      : tb_pu_div_queued
// Description : Self-checking bench for pu_div_queued (signed radix-2 build and
//               unsigned radix-16 build) against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_div_queued;

    localparam int c_K  = 32;
    localparam int c_QD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signal_wr = 1'b0, signal_sel = 1'b0, signal_oe = 1'b0;
    logic        res_select = 1'b0, signal_pop = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  attr_in = '0;
    logic [31:0] data_out;
    logic [3:0]  attr_out;
    logic        busy, full;

    logic        u_wr = 1'b0, u_sel = 1'b0, u_oe = 1'b0, u_rsel = 1'b0, u_pop = 1'b0;
    logic [31:0] u_din = '0;
    logic [3:0]  u_ain = '0;
    logic [31:0] u_dout;
    logic [3:0]  u_aout;
    logic        u_busy, u_full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pu_div_queued dut (
        .clk(clk), .rst(rst), .signal_wr(signal_wr), .signal_sel(signal_sel),
        .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe),
        .res_select(res_select), .signal_pop(signal_pop), .data_out(data_out),
        .attr_out(attr_out), .busy(busy), .full(full)
    );

    pu_div_queued #(.SIGNED(0), .STEPS_PER_CYCLE(4)) dut_u (
        .clk(clk), .rst(rst), .signal_wr(u_wr), .signal_sel(u_sel),
        .data_in(u_din), .attr_in(u_ain), .signal_oe(u_oe),
        .res_select(u_rsel), .signal_pop(u_pop), .data_out(u_dout),
        .attr_out(u_aout), .busy(u_busy), .full(u_full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        inv;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_dvd, m_pa, m_pb, m_ea, m_eb;
    logic        m_dvd_inv, m_pi, m_ei;
    bit          m_pv, m_eng, m_on;
    int          m_cnt;

    function automatic ent_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic inv);
        ent_t e;
        int   sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            e.q = '0; e.r = a; e.inv = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.inv = 1'b1;
        end else begin
            e.q = sa / sb; e.r = sa % sb; e.inv = inv;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        bit          pop_eff, push_ok, load, accept;
        logic [31:0] exp_d;
        logic [3:0]  exp_a;
        if (rst) begin
            mq.delete();
            m_pv = 0; m_eng = 0; m_cnt = 0;
            m_dvd = '0; m_dvd_inv = 1'b0;
            m_on = 1;
        end else begin
            pop_eff = signal_pop && (mq.size() > 0);
            push_ok = m_eng && (m_cnt == 1) && ((mq.size() < c_QD) || pop_eff);
            load    = m_pv && (!m_eng || push_ok);
            accept  = signal_wr && signal_sel && (!m_pv || load);
            if (pop_eff) void'(mq.pop_front());
            if (push_ok) begin
                mq.push_back(ref_div(m_ea, m_eb, m_ei));
                m_eng = 0;
            end else if (m_eng && m_cnt > 1) begin
                m_cnt--;
            end
            if (load) begin
                m_eng = 1; m_cnt = c_K + 1;
                m_ea = m_pa; m_eb = m_pb; m_ei = m_pi;
                m_pv = 0;
            end
            if (accept) begin
                m_pv = 1; m_pa = m_dvd; m_pb = data_in; m_pi = m_dvd_inv | attr_in[0];
            end
            if (signal_wr && !signal_sel) begin
                m_dvd = data_in; m_dvd_inv = attr_in[0];
            end
        end
        #1;
        if (m_on) begin
            exp_d = '0;
            exp_a = '0;
            if (signal_oe) begin
                if (mq.size() == 0) begin
                    exp_a = 4'b0001;
                end else begin
                    exp_d = res_select ? mq[0].r : mq[0].q;
                    exp_a = {3'b000, mq[0].inv};
                end
            end
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_pv});
            chk("cyc_full", {31'd0, full}, {31'd0, (mq.size() == c_QD)});
            chk("cyc_data", data_out, exp_d);
            chk("cyc_attr", {28'd0, attr_out}, {28'd0, exp_a});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic issue(input bit u, input logic sel, input logic [31:0] d, input logic inv);
        @(negedge clk);
        if (u) begin
            u_wr = 1'b1; u_sel = sel; u_din = d; u_ain = {3'b000, inv};
        end else begin
            signal_wr = 1'b1; signal_sel = sel; data_in = d; attr_in = {3'b000, inv};
        end
        @(posedge clk);
        #2;
        signal_wr = 1'b0;
        u_wr      = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk);
        signal_pop = 1'b1;
        @(posedge clk);
        #2;
        signal_pop = 1'b0;
    endtask

    task automatic wait_not_busy();
        int t;
        t = 0;
        while (busy && t < 200) begin
            step(1);
            t++;
        end
        chk("wait_busy_bound", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npop;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_attr", {28'd0, attr_out}, 32'd0);
        signal_oe = 1'b1;
        u_oe      = 1'b1;

        // basic signed divide with latency K+2
        issue(0, 0, -100, 0);
        issue(0, 1, 4, 0);
        step(c_K + 1);
        chk("t1_not_yet_attr", {28'd0, attr_out}, 32'd1);
        chk("t1_not_yet_data", data_out, 32'd0);
        step(1);
        chk("t1_quo", data_out, 32'hFFFF_FFE7);
        res_select = 1'b1; #1;
        chk("t1_rem", data_out, 32'd0);
        chk("t1_attr", {28'd0, attr_out}, 32'd0);
        res_select = 1'b0;
        pop1();

        // back-to-back with invalid propagation
        issue(0, 0, 100, 0);
        issue(0, 1, -5, 0);
        issue(0, 0, 100, 1);
        chk("t2_busy_low", {31'd0, busy}, 32'd0);
        issue(0, 1, 3, 0);
        step(2 * c_K + 5);
        chk("t2a_quo", data_out, 32'hFFFF_FFEC);
        res_select = 1'b1; #1;
        chk("t2a_rem", data_out, 32'd0);
        chk("t2a_attr", {28'd0, attr_out}, 32'd0);
        res_select = 1'b0;
        pop1();
        chk("t2b_quo", data_out, 32'd33);
        res_select = 1'b1; #1;
        chk("t2b_rem", data_out, 32'd1);
        chk("t2b_attr", {28'd0, attr_out}, 32'd1);
        res_select = 1'b0;
        pop1();

        // divide-by-zero and signed overflow
        issue(0, 0, 100, 0);
        issue(0, 1, 0, 0);
        issue(0, 0, 32'h8000_0000, 0);
        issue(0, 1, 32'hFFFF_FFFF, 0);
        step(2 * c_K + 5);
        chk("t3a_quo", data_out, 32'd0);
        chk("t3a_attr", {28'd0, attr_out}, 32'd1);
        res_select = 1'b1; #1;
        chk("t3a_rem", data_out, 32'd100);
        res_select = 1'b0;
        pop1();
        chk("t3b_quo", data_out, 32'h8000_0000);
        chk("t3b_attr", {28'd0, attr_out}, 32'd1);
        res_select = 1'b1; #1;
        chk("t3b_rem", data_out, 32'd0);
        res_select = 1'b0;
        pop1();

        // queue full and FIX stall
        issue(0, 0, 10, 0);
        for (int j = 0; j < 6; j++) begin
            wait_not_busy();
            issue(0, 1, 3, 0);
        end
        step(2 * c_K + 10);
        chk("t4_full", {31'd0, full}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        issue(0, 1, 3, 0);
        pop1();
        chk("t4_full_after_pop", {31'd0, full}, 32'd1);
        chk("t4_busy_after_pop", {31'd0, busy}, 32'd0);
        step(c_K + 5);
        npop = 0;
        while (attr_out == 4'd0 && npop < 10) begin
            chk("t4_head_quo", data_out, 32'd3);
            pop1();
            npop++;
        end
        chk("t4_remaining_entries", npop, 32'd5);

        // empty / disabled outputs and pop on empty
        chk("t5_empty_data", data_out, 32'd0);
        chk("t5_empty_attr", {28'd0, attr_out}, 32'd1);
        pop1();
        issue(0, 0, 9, 0);
        issue(0, 1, 2, 0);
        step(c_K + 5);
        signal_oe = 1'b0; #1;
        chk("t5_oe0_data", data_out, 32'd0);
        chk("t5_oe0_attr", {28'd0, attr_out}, 32'd0);
        signal_oe = 1'b1; #1;
        chk("t5_quo", data_out, 32'd4);
        res_select = 1'b1; #1;
        chk("t5_rem", data_out, 32'd1);
        res_select = 1'b0;
        pop1();

        // reset during RUN discards the job
        issue(0, 0, 7, 0);
        issue(0, 1, 2, 0);
        step(5);
        signal_oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_data", data_out, 32'd0);
        chk("t6_rst_attr", {28'd0, attr_out}, 32'd0);
        signal_oe = 1'b1;
        issue(0, 0, 7, 0);
        issue(0, 1, 2, 0);
        step(c_K + 1);
        chk("t6_not_yet_attr", {28'd0, attr_out}, 32'd1);
        step(1);
        chk("t6_quo", data_out, 32'd3);
        res_select = 1'b1; #1;
        chk("t6_rem", data_out, 32'd1);
        res_select = 1'b0;
        pop1();

        // unsigned radix-16 build: latency 10
        chk("u_empty_attr", {28'd0, u_aout}, 32'd1);
        issue(1, 0, 32'hFFFF_FFFF, 0);
        issue(1, 1, 16, 0);
        step(9);
        chk("u_not_yet_attr", {28'd0, u_aout}, 32'd1);
        chk("u_not_yet_data", u_dout, 32'd0);
        step(1);
        chk("u_quo", u_dout, 32'h0FFF_FFFF);
        u_rsel = 1'b1; #1;
        chk("u_rem", u_dout, 32'd15);
        chk("u_attr", {28'd0, u_aout}, 32'd0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
